// File: rtl/video_irq_ctrl.sv
// Interrupt controller between the video timing stage and the 8080 CPU core.
// Rising edges of the mid_screen / vblank levels become pending RST interrupts,
// which are presented to the CPU one at a time with vblank taking priority.
//
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   mid_screen       level strobe from video stage (RST_MID source)
//   vblank           level strobe from video stage (RST_VBL source)
//   int_en           CPU interrupt-enable flag
//   int_ack          CPU interrupt-acknowledge (opcode fetch)
//   int_req          interrupt request to CPU
//   int_opcode       RST opcode, valid while int_req or int_ack is high
//   irq_pending      {vbl_pending, mid_pending}
//   overrun_mid/vbl  saturating counts of dropped events per source
module video_irq_ctrl #(
   parameter int unsigned RST_MID   = 1,
   parameter int unsigned RST_VBL   = 2,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mid_screen,
   input  logic                 vblank,
   input  logic                 int_en,
   input  logic                 int_ack,
   output logic                 int_req,
   output logic [7:0]           int_opcode,
   output logic [1:0]           irq_pending,
   output logic [CNT_WIDTH-1:0] overrun_mid,
   output logic [CNT_WIDTH-1:0] overrun_vbl
);

   localparam logic [7:0] OP_MID = 8'hC7 | 8'((RST_MID % 8) << 3);
   localparam logic [7:0] OP_VBL = 8'hC7 | 8'((RST_VBL % 8) << 3);

   typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

   state_e               state_q, state_d;
   logic                 mid_prev_q, vbl_prev_q;
   logic [1:0]           pend_q, pend_d;
   logic                 src_vbl_q, src_vbl_d;
   logic [7:0]           op_q, op_d;
   logic [CNT_WIDTH-1:0] cnt_mid_q, cnt_mid_d;
   logic [CNT_WIDTH-1:0] cnt_vbl_q, cnt_vbl_d;

   logic mid_rise, vbl_rise;
   logic clr_mid, clr_vbl;
   logic ov_mid, ov_vbl;

   assign mid_rise = mid_screen & ~mid_prev_q;
   assign vbl_rise = vblank & ~vbl_prev_q;

   // FSM next state; clr_* flags clear the latched source on acknowledge
   always_comb begin
      state_d   = state_q;
      src_vbl_d = src_vbl_q;
      op_d      = op_q;
      clr_mid   = 1'b0;
      clr_vbl   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (int_en && (pend_q != 2'b00)) begin
               src_vbl_d = pend_q[1];
               op_d      = pend_q[1] ? OP_VBL : OP_MID;
               state_d   = StReq;
            end
         end
         StReq: begin
            if (int_ack) begin
               clr_vbl = src_vbl_q;
               clr_mid = ~src_vbl_q;
               state_d = StHold;
            end else if (!int_en) begin
               state_d = StIdle;
            end
         end
         StHold: begin
            if (!int_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // A new rise beats a same-cycle clear; an overrun is a rise onto a bit
   // that stays set regardless of the rise.
   always_comb begin
      pend_d[0] = mid_rise | (pend_q[0] & ~clr_mid);
      pend_d[1] = vbl_rise | (pend_q[1] & ~clr_vbl);
      ov_mid    = mid_rise & pend_q[0] & ~clr_mid;
      ov_vbl    = vbl_rise & pend_q[1] & ~clr_vbl;
      cnt_mid_d = cnt_mid_q;
      cnt_vbl_d = cnt_vbl_q;
      if (ov_mid && (cnt_mid_q != {CNT_WIDTH{1'b1}})) cnt_mid_d = cnt_mid_q + 1'b1;
      if (ov_vbl && (cnt_vbl_q != {CNT_WIDTH{1'b1}})) cnt_vbl_d = cnt_vbl_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         // History resets high so a level already asserted at release is ignored
         mid_prev_q <= 1'b1;
         vbl_prev_q <= 1'b1;
         pend_q     <= 2'b00;
         src_vbl_q  <= 1'b0;
         op_q       <= 8'h00;
         cnt_mid_q  <= '0;
         cnt_vbl_q  <= '0;
      end else begin
         state_q    <= state_d;
         mid_prev_q <= mid_screen;
         vbl_prev_q <= vblank;
         pend_q     <= pend_d;
         src_vbl_q  <= src_vbl_d;
         op_q       <= op_d;
         cnt_mid_q  <= cnt_mid_d;
         cnt_vbl_q  <= cnt_vbl_d;
      end
   end

   assign int_req     = (state_q == StReq);
   assign int_opcode  = op_q;
   assign irq_pending = pend_q;
   assign overrun_mid = cnt_mid_q;
   assign overrun_vbl = cnt_vbl_q;

endmodule

// File: tb/tb_video_irq_ctrl.sv
// Self-checking bench for video_irq_ctrl. Expected opcodes go into a
// scoreboard queue when the triggering edge is driven and are popped when the
// DUT raises int_req. A second instance with 2-bit counters covers saturation.
module tb_video_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mid_screen, vblank, int_en, int_ack;
   logic       int_req;
   logic [7:0] int_opcode;
   logic [1:0] irq_pending;
   logic [7:0] overrun_mid, overrun_vbl;

   logic       mid2, vbl2, en2, ack2;
   logic       int_req2;
   logic [7:0] int_opcode2;
   logic [1:0] irq_pending2;
   logic [1:0] overrun_mid2, overrun_vbl2;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_op;
   bit         ok;

   always #5 clk = ~clk;

   video_irq_ctrl #(.RST_MID(1), .RST_VBL(2), .CNT_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mid_screen (mid_screen),
      .vblank     (vblank),
      .int_en     (int_en),
      .int_ack    (int_ack),
      .int_req    (int_req),
      .int_opcode (int_opcode),
      .irq_pending(irq_pending),
      .overrun_mid(overrun_mid),
      .overrun_vbl(overrun_vbl)
   );

   video_irq_ctrl #(.RST_MID(1), .RST_VBL(2), .CNT_WIDTH(2)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .mid_screen (mid2),
      .vblank     (vbl2),
      .int_en     (en2),
      .int_ack    (ack2),
      .int_req    (int_req2),
      .int_opcode (int_opcode2),
      .irq_pending(irq_pending2),
      .overrun_mid(overrun_mid2),
      .overrun_vbl(overrun_vbl2)
   );

   // Advance one clock; outputs are stable and inputs may be driven on return
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int max_cycles, output bit found);
      found = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         tick();
         if (int_req === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_exp(output logic [7:0] op);
      op = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mid_screen = 1'b1; vblank = 1'b0; int_en = 1'b1; int_ack = 1'b0;
      mid2 = 1'b0; vbl2 = 1'b0; en2 = 1'b0; ack2 = 1'b0;
      repeat (3) tick();
      checks++;
      if (int_req !== 1'b0 || int_opcode !== 8'h00 || irq_pending !== 2'b00 ||
          overrun_mid !== 8'd0 || overrun_vbl !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: req=%b op=%h pend=%b ovm=%0d ovv=%0d want 0 00 00 0 0",
                  int_req, int_opcode, irq_pending, overrun_mid, overrun_vbl);
      end
      rst_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (int_req !== 1'b0 || irq_pending !== 2'b00) ok = 1'b1;
      end
      checks++;
      if (ok) begin
         errors++;
         $display("FAIL reset_level_high: spurious req/pending got %b/%b want 0/00",
                  int_req, irq_pending);
      end
      mid_screen = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_basic_mid();
      bit seen;
      mid_screen = 1'b1;
      exp_q.push_back(8'hCF);
      tick();  // edge k
      checks++;
      if (int_req !== 1'b0 || irq_pending !== 2'b01) begin
         errors++;
         $display("FAIL mid_edge_k: req=%b pend=%b want 0/01", int_req, irq_pending);
      end
      tick();  // edge k+1
      pop_exp(exp_op);
      checks++;
      if (int_req !== 1'b1 || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL mid_req_latency: req=%b op=%h want 1/%h", int_req, int_opcode, exp_op);
      end
      int_ack = 1'b1;
      repeat (3) tick();
      int_ack = 1'b0;
      tick();
      checks++;
      if (int_req !== 1'b0 || irq_pending !== 2'b00) begin
         errors++;
         $display("FAIL mid_after_ack: req=%b pend=%b want 0/00", int_req, irq_pending);
      end
      seen = 1'b0;
      for (int i = 0; i < 794; i++) begin
         tick();
         if (int_req !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_level_no_repeat: second request seen=1 want 0");
      end
      mid_screen = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_priority();
      mid_screen = 1'b1; vblank = 1'b1;
      exp_q.push_back(8'hD7);
      exp_q.push_back(8'hCF);
      tick();
      checks++;
      if (irq_pending !== 2'b11) begin
         errors++;
         $display("FAIL prio_pending: got %b want 11", irq_pending);
      end
      wait_req(4, ok);
      pop_exp(exp_op);
      checks++;
      if (!ok || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL prio_first: req=%b op=%h want 1/%h", ok, int_opcode, exp_op);
      end
      int_ack = 1'b1;
      tick();
      checks++;
      if (int_req !== 1'b0 || irq_pending !== 2'b01) begin
         errors++;
         $display("FAIL prio_ack_vbl: req=%b pend=%b want 0/01", int_req, irq_pending);
      end
      int_ack = 1'b0;
      wait_req(6, ok);
      pop_exp(exp_op);
      checks++;
      if (!ok || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL prio_second: req=%b op=%h want 1/%h", ok, int_opcode, exp_op);
      end
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      tick();
      checks++;
      if (irq_pending !== 2'b00 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL prio_drain: req=%b pend=%b want 0/00", int_req, irq_pending);
      end
      mid_screen = 1'b0; vblank = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_mask_withdraw();
      bit seen;
      int_en = 1'b0;
      vblank = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (int_req !== 1'b0) seen = 1'b1;
      end
      vblank = 1'b0;
      checks++;
      if (seen || irq_pending !== 2'b10) begin
         errors++;
         $display("FAIL mask_hold: req_seen=%b pend=%b want 0/10", seen, irq_pending);
      end
      exp_q.push_back(8'hD7);
      int_en = 1'b1;
      wait_req(4, ok);
      pop_exp(exp_op);
      checks++;
      if (!ok || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL mask_enable_req: req=%b op=%h want 1/%h", ok, int_opcode, exp_op);
      end
      int_en = 1'b0;
      tick();
      checks++;
      if (int_req !== 1'b0 || irq_pending !== 2'b10) begin
         errors++;
         $display("FAIL withdraw: req=%b pend=%b want 0/10", int_req, irq_pending);
      end
      exp_q.push_back(8'hD7);
      int_en = 1'b1;
      wait_req(4, ok);
      pop_exp(exp_op);
      checks++;
      if (!ok || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL withdraw_reraise: req=%b op=%h want 1/%h", ok, int_opcode, exp_op);
      end
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_overrun();
      int_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid_screen = 1'b1; mid2 = 1'b1;
         tick();
         mid_screen = 1'b0; mid2 = 1'b0;
         tick();
      end
      checks++;
      if (overrun_mid !== 8'd2 || irq_pending !== 2'b01) begin
         errors++;
         $display("FAIL overrun_three: ovm=%0d pend=%b want 2/01", overrun_mid, irq_pending);
      end
      checks++;
      if (overrun_mid2 !== 2'd2) begin
         errors++;
         $display("FAIL overrun_small_three: ovm=%0d want 2", overrun_mid2);
      end
      for (int i = 0; i < 7; i++) begin
         mid2 = 1'b1;
         tick();
         mid2 = 1'b0;
         tick();
      end
      checks++;
      if (overrun_mid2 !== 2'd3 || irq_pending2 !== 2'b01 || int_req2 !== 1'b0) begin
         errors++;
         $display("FAIL overrun_saturate: ovm=%0d pend=%b req=%b want 3/01/0",
                  overrun_mid2, irq_pending2, int_req2);
      end
      exp_q.push_back(8'hCF);
      int_en = 1'b1;
      wait_req(4, ok);
      pop_exp(exp_op);
      checks++;
      if (!ok || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL overrun_single_deliver: req=%b op=%h want 1/%h", ok, int_opcode, exp_op);
      end
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_collision();
      mid_screen = 1'b1;
      exp_q.push_back(8'hCF);
      tick();
      mid_screen = 1'b0;
      tick();
      pop_exp(exp_op);
      checks++;
      if (int_req !== 1'b1 || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL coll_first: req=%b op=%h want 1/%h", int_req, int_opcode, exp_op);
      end
      // New rise lands exactly on the ack that clears mid
      int_ack = 1'b1; mid_screen = 1'b1;
      exp_q.push_back(8'hCF);
      tick();
      checks++;
      if (irq_pending !== 2'b01 || overrun_mid !== 8'd2 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL coll_set_wins: pend=%b ovm=%0d req=%b want 01/2/0",
                  irq_pending, overrun_mid, int_req);
      end
      int_ack = 1'b0; mid_screen = 1'b0;
      tick();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL coll_idle_gap: req=%b want 0", int_req);
      end
      wait_req(4, ok);
      pop_exp(exp_op);
      checks++;
      if (!ok || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL coll_second: req=%b op=%h want 1/%h", ok, int_opcode, exp_op);
      end
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset_mid_op();
      vblank = 1'b1;
      exp_q.push_back(8'hD7);
      wait_req(4, ok);
      pop_exp(exp_op);
      checks++;
      if (!ok || int_opcode !== exp_op) begin
         errors++;
         $display("FAIL rst_op_req: req=%b op=%h want 1/%h", ok, int_opcode, exp_op);
      end
      vblank = 1'b0;
      rst_n = 1'b0;
      tick();
      checks++;
      if (int_req !== 1'b0 || int_opcode !== 8'h00 || irq_pending !== 2'b00 ||
          overrun_mid !== 8'd0 || overrun_vbl !== 8'd0 || overrun_mid2 !== 2'd0) begin
         errors++;
         $display("FAIL rst_in_req: req=%b op=%h pend=%b ovm=%0d ovv=%0d ovm2=%0d want all 0",
                  int_req, int_opcode, irq_pending, overrun_mid, overrun_vbl, overrun_mid2);
      end
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (int_req !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_idle: req=%b leftover_expected=%0d want 0/0", int_req,
                  exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_mid();
      test_priority();
      test_mask_withdraw();
      test_overrun();
      test_collision();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_irq_ctrl.md
Name: video_irq_ctrl

Overview:
Interrupt controller between the video timing stage and the 8080 CPU core. It consumes the video stage's mid_screen and vblank level strobes and turns each rising edge into a pending RST interrupt: RST 1 at mid-screen, RST 2 at vblank. It drives the CPU's interrupt request and supplies the RST opcode during the CPU's interrupt-acknowledge cycle. It also keeps saturating overrun counters so firmware/debug logic can see dropped interrupts.

Parameters:
RST_MID, 1, RST vector number for the mid_screen source (opcode = 8'hC7 | RST_MID<<3 = 8'hCF)
RST_VBL, 2, RST vector number for the vblank source (opcode 8'hD7)
CNT_WIDTH, 8, width of each overrun counter

Ports:
clk  in  1  system clock (same domain as the video stage and CPU)
rst_n  in  1  reset: synchronous, active-low
mid_screen  in  1  level from video stage; high for one full scanline at y=240
vblank  in  1  level from video stage; high for one full scanline at vblank start
int_en  in  1  CPU interrupt-enable flag (EI/DI state)
int_ack  in  1  CPU interrupt-acknowledge; high for 1+ cycles while the CPU fetches the opcode
int_req  out  1  interrupt request to CPU
int_opcode  out  8  RST opcode; valid while int_req or int_ack is high
irq_pending  out  2  {vbl_pending, mid_pending} status
overrun_mid  out  CNT_WIDTH  saturating count of dropped mid_screen events
overrun_vbl  out  CNT_WIDTH  saturating count of dropped vblank events

Behaviour:
- Reset (rst_n low at a clk edge): int_req=0, int_opcode=8'h00, irq_pending=2'b00, both overrun counters=0, FSM=IDLE. Edge-detect history registers (mid_prev, vbl_prev) reset to 1, so a level already high at reset release does not fire.
- Edge detect: rise = level & ~prev; prev <= level every cycle. A rise sets the pending bit at that same clock edge. irq_pending shows the bit from the next cycle on.
- Overrun: a rise while that source's pending bit is already set and not being cleared this cycle increments that source's counter. The counter saturates at all-ones. The pending bit stays set, so only one interrupt is delivered.
- Same-cycle rise and ack-clear of the same source: the set wins. The pending bit remains 1 and no overrun is counted.
- Priority: vblank (RST_VBL) over mid_screen (RST_MID) when both are pending in IDLE.
- FSM:
  IDLE: int_req=0. If int_en and any pending bit is set, latch the chosen source and int_opcode, then go to REQ.
  REQ: int_req=1 and int_opcode stable.
    On int_ack=1: clear the latched source's pending bit, deassert int_req, and go to HOLD.
    If int_en=0 and int_ack=0: withdraw to IDLE. Pending is retained and int_req=0 next cycle.
    A higher-priority source arriving in REQ does not change the latched opcode.
  HOLD: int_req=0 and int_opcode held. Stay in HOLD while int_ack=1; go to IDLE when int_ack=0. The next request can be raised no earlier than one cycle after IDLE is re-entered.
- Latency: the first edge sampling mid_screen=1 (prev=0) is edge k. Pending is set at k, the FSM enters REQ at k+1, and int_req is high after edge k+1. This assumes int_en=1 and the FSM is IDLE.
- int_ack seen in IDLE or with no request outstanding is ignored: no state change, no pending cleared.
- int_opcode keeps its last value in IDLE. It is only guaranteed valid in REQ/HOLD.
- Reset mid-operation (REQ or HOLD) drops the request immediately at that edge. Pending events and counters are lost.

Test Plan:
- Basic mid: int_en=1, pulse mid_screen high for 800 cycles. Expect int_req=1 two edges after the rise and int_opcode=8'hCF. Ack 3 cycles, then expect int_req=0 and irq_pending=00. No second request while mid_screen stays high.
- Priority: assert vblank and mid_screen rises in the same cycle. Expect first request with opcode 8'hD7. After ack completes, expect a second request with 8'hCF.
- Masking/withdraw: int_en=0, vblank rise. Expect irq_pending=2'b10 and int_req stays 0. Then int_en=1 gives a request with 8'hD7. Drop int_en before ack: int_req=0 next cycle and pending stays 2'b10.
- Overrun: int_en=0, issue 3 mid_screen rises. Expect overrun_mid=2 and irq_pending=01. With CNT_WIDTH=2, issue 10 rises and expect saturation at 3.
- Set/clear collision: mid_screen rise in the exact cycle int_ack clears mid. Expect pending still 1, overrun_mid unchanged, and a new request after HOLD exits.
- Reset: hold mid_screen high through rst_n low→high. Expect no request after release. Assert rst_n low during REQ: int_req=0 and all status is 0 at the next edge.
